port_uart_tx: RTL and testbench

- Serial output stage sitting directly downstream of the 16-bit bus I/O port register.
- Consumes the port's latched parallel word and its write strobe, and transmits the word as two 8N1 UART frames, low byte first.
- Exposes a 3-bit status word on the shared 16-bit tri-state bus for CPU polling.
- Contains a single-word holding buffer so the CPU can queue one word while another is in flight.

---
 rtl/port_uart_tx.sv | 207 ++++++++++++++++++++
 tb/tb_port_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_uart_tx.sv
// port_uart_tx: serializes each 16-bit port word as two UART frames, low byte first, and buffers one further word.
// Build option PORT_UART_TX_PARITY_EN adds an even-parity bit after the data bits of each byte.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line idle high, waiting for a new word
// S_START  | start bit (txd=0) for one bit-time
// S_DATA   | data bits LSB first, r_bit = 0..7
// S_PARITY | even parity of the current byte (parity build)
// S_STOP   | stop bit (txd=1); then next byte, next word or idle
module port_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [15:0] dataIn,
   input  logic        wEn,
   input  logic        rEn,
   inout  wire  [15:0] bus,
   output logic        txd,
   output logic        busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PORT_UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t             r_state;
   state_t             w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sync;
   logic               r_wen_d;
   logic               w_new_word;

   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_tc;

   logic [2:0]         r_bit;
   logic [2:0]         w_bit_nxt;
   logic               r_byte_sel;
   logic               w_byte_sel_nxt;
   logic [15:0]        r_shift;
   logic [15:0]        w_shift_nxt;
   logic [15:0]        r_hold;
   logic [15:0]        w_hold_nxt;
   logic               r_pending;
   logic               w_pending_nxt;
   logic               r_overrun;
   logic               w_overrun_nxt;
   logic               w_overrun_ev;
   logic               w_word_done;
   logic [7:0]         w_byte_nxt;
   logic               r_txd;
   logic               w_txd_nxt;

   // wEn is asynchronous: synchronize, then detect the rising edge
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_sync  <= '0;
         r_wen_d <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], wEn};
         r_wen_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign w_new_word = r_sync[SYNC_STAGES-1] & ~r_wen_d;
   assign w_tc       = (r_cnt == '0);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = (r_state == S_IDLE || w_tc) ? CNT_LOAD : (r_cnt - CNT_ONE);
      w_bit_nxt      = r_bit;
      w_byte_sel_nxt = r_byte_sel;
      w_shift_nxt    = r_shift;
      w_hold_nxt     = r_hold;
      w_pending_nxt  = r_pending;
      w_overrun_ev   = 1'b0;
      w_word_done    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_new_word) begin
               w_shift_nxt    = dataIn;
               w_byte_sel_nxt = 1'b0;
               w_state_nxt    = S_START;
            end
         end
         S_START: begin
            if (w_tc) begin
               w_bit_nxt   = 3'd0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_tc) begin
               if (r_bit == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
`ifdef PORT_UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_tc) begin
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (w_tc) begin
               if (!r_byte_sel) begin
                  w_byte_sel_nxt = 1'b1;
                  w_state_nxt    = S_START;
               end else begin
                  w_word_done    = 1'b1;
                  w_byte_sel_nxt = 1'b0;
                  if (r_pending) begin
                     w_shift_nxt = r_hold;
                     w_state_nxt = S_START;
                  end else if (w_new_word) begin
                     w_shift_nxt = dataIn;
                     w_state_nxt = S_START;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // A word arriving as the holding register drains refills it without an overrun
      if (w_new_word && (r_state != S_IDLE) && !(w_word_done && !r_pending)) begin
         if (!r_pending || w_word_done) begin
            w_hold_nxt    = dataIn;
            w_pending_nxt = 1'b1;
         end else begin
            w_overrun_ev  = 1'b1;
         end
      end else if (w_word_done && r_pending) begin
         w_pending_nxt = 1'b0;
      end

      w_overrun_nxt = w_overrun_ev | (r_overrun & ~rEn);

      w_byte_nxt = w_byte_sel_nxt ? w_shift_nxt[15:8] : w_shift_nxt[7:0];
      case (w_state_nxt)
         S_START:  w_txd_nxt = 1'b0;
         S_DATA:   w_txd_nxt = w_byte_nxt[w_bit_nxt];
`ifdef PORT_UART_TX_PARITY_EN
         S_PARITY: w_txd_nxt = ^w_byte_nxt;
`endif
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cnt      <= CNT_LOAD;
         r_bit      <= 3'd0;
         r_byte_sel <= 1'b0;
         r_shift    <= '0;
         r_hold     <= '0;
         r_pending  <= 1'b0;
         r_overrun  <= 1'b0;
         r_txd      <= 1'b1;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_byte_sel <= w_byte_sel_nxt;
         r_shift    <= w_shift_nxt;
         r_hold     <= w_hold_nxt;
         r_pending  <= w_pending_nxt;
         r_overrun  <= w_overrun_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

   assign txd  = r_txd;
   assign busy = (r_state != S_IDLE);
   assign bus  = rEn ? {13'b0, r_overrun, r_pending, busy} : 16'bz;

endmodule

// File: tb/tb_port_uart_tx.sv
// tb_port_uart_tx: directed checks of framing, queueing, overrun, status reads and reset for port_uart_tx.
// Build with PORT_UART_TX_PARITY_EN defined to exercise the parity framing.
module tb_port_uart_tx;

   localparam int CPB = 16;
`ifdef PORT_UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME = FB * CPB;
   localparam int WORD  = 2 * FRAME;

   logic        clk;
   logic        resetN;
   logic [15:0] dataIn;
   logic        wEn;
   logic        rEn;
   wire  [15:0] bus;
   logic        txd;
   logic        busy;

   int n_checks;
   int n_fail;

   port_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .dataIn (dataIn),
      .wEn    (wEn),
      .rEn    (rEn),
      .bus    (bus),
      .txd    (txd),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one-cycle status read, sampled on the falling edge
   task automatic rd_status(input string tag, input logic [15:0] exp);
      rEn = 1'b1;
      @(negedge clk);
      chk(tag, bus, exp);
      @(posedge clk);
      #1;
      rEn = 1'b0;
   endtask

   // strobe from idle; returns aligned one tick after the start-bit edge
   task automatic launch(input string tag, input logic [15:0] d);
      dataIn = d;
      wEn    = 1'b1;
      wait_clk(2);
      chk({tag, "_pre_start"}, 16'(txd), 16'd1);
      wait_clk(1);
      wEn    = 1'b0;
      chk({tag, "_start_fall"}, 16'(txd), 16'd0);
      chk({tag, "_busy_rise"}, 16'(busy), 16'd1);
   endtask

   task automatic queue_word(input logic [15:0] d);
      dataIn = d;
      wEn    = 1'b1;
      wait_clk(3);
      wEn    = 1'b0;
   endtask

   // entered 'skip' clocks after the start-bit edge; leaves mid stop bit
   task automatic check_frame(input string tag, input logic [7:0] b, input int skip);
      wait_clk(CPB / 2 - skip);
      chk({tag, "_startbit"}, 16'(txd), 16'd0);
      for (int i = 0; i < 8; i++) begin
         wait_clk(CPB);
         chk($sformatf("%s_bit%0d", tag, i), 16'(txd), 16'(b[i]));
      end
`ifdef PORT_UART_TX_PARITY_EN
      wait_clk(CPB);
      chk({tag, "_parity"}, 16'(txd), 16'(^b));
`endif
      wait_clk(CPB);
      chk({tag, "_stopbit"}, 16'(txd), 16'd1);
   endtask

   task automatic check_word(input string tag, input logic [15:0] w, input int skip);
      check_frame({tag, "_lo"}, w[7:0], skip);
      wait_clk(CPB / 2);
      check_frame({tag, "_hi"}, w[15:8], 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      resetN   = 1'b0;
      dataIn   = 16'h0000;
      wEn      = 1'b0;
      rEn      = 1'b0;

      wait_clk(3);
      chk("rst_txd", 16'(txd), 16'd1);
      chk("rst_busy", 16'(busy), 16'd0);
      rd_status("rst_status", 16'h0000);
      resetN = 1'b1;
      wait_clk(4);

      // single word, LSB-first bytes 0x5A then 0xA5
      launch("sw", 16'hA55A);
      check_word("sw", 16'hA55A, 0);
      wait_clk(CPB / 2 - 1);
      chk("sw_busy_last", 16'(busy), 16'd1);
      wait_clk(1);
      chk("sw_busy_drop", 16'(busy), 16'd0);
      chk("sw_idle_txd", 16'(txd), 16'd1);
      wait_clk(10);

      // second word queued during the first
      launch("q", 16'h0F0F);
      wait_clk(5);
      queue_word(16'h1234);
      rd_status("q_status", 16'h0003);
      wait_clk(WORD - 10);
      chk("q_w1_stop", 16'(txd), 16'd1);
      wait_clk(1);
      chk("q_w2_start", 16'(txd), 16'd0);
      rd_status("q_pend_clr", 16'h0001);
      check_word("q_w2", 16'h1234, 1);
      wait_clk(CPB / 2);
      chk("q_idle", 16'(busy), 16'd0);
      wait_clk(10);

      // overrun, read-to-clear, and a set on the same edge as a read
      launch("ov", 16'h1111);
      wait_clk(5);
      queue_word(16'h2B1C);
      wait_clk(5);
      queue_word(16'h3333);
      rd_status("ov_status", 16'h0007);
      rd_status("ov_cleared", 16'h0003);
      wait_clk(5);
      dataIn = 16'h4444;
      wEn    = 1'b1;
      wait_clk(2);
      rd_status("col_during", 16'h0003);
      wEn    = 1'b0;
      rd_status("col_after", 16'h0007);
      rd_status("col_cleared", 16'h0003);
      wait_clk(WORD - 28);
      chk("ov_w2_start", 16'(txd), 16'd0);
      check_word("ov_w2", 16'h2B1C, 0);
      wait_clk(CPB / 2);
      chk("ov_idle_busy", 16'(busy), 16'd0);
      rd_status("ov_final_status", 16'h0000);
      wait_clk(30);
      chk("ov_no_drop_word", 16'(txd), 16'd1);

      // new word on the last stop edge while the holding register drains
      launch("s1", 16'h0000);
      wait_clk(5);
      queue_word(16'h6655);
      wait_clk(WORD - 11);
      dataIn = 16'h9988;
      wEn    = 1'b1;
      wait_clk(3);
      wEn    = 1'b0;
      chk("s1_w2_start", 16'(txd), 16'd0);
      rd_status("s1_status", 16'h0003);
      check_word("s1_w2", 16'h6655, 1);
      wait_clk(CPB / 2);
      chk("s1_w3_start", 16'(txd), 16'd0);
      rd_status("s1_status2", 16'h0001);
      check_word("s1_w3", 16'h9988, 1);
      wait_clk(CPB / 2);
      chk("s1_idle", 16'(busy), 16'd0);
      wait_clk(10);

      // new word on the last stop edge with nothing pending
      launch("s0", 16'h00FF);
      wait_clk(WORD - 3);
      dataIn = 16'h8001;
      wEn    = 1'b1;
      wait_clk(2);
      chk("s0_w1_stop", 16'(txd), 16'd1);
      wait_clk(1);
      wEn    = 1'b0;
      chk("s0_w2_start", 16'(txd), 16'd0);
      check_word("s0_w2", 16'h8001, 0);
      wait_clk(CPB / 2);
      chk("s0_idle", 16'(busy), 16'd0);
      wait_clk(10);

      // parity bits 0 (low byte) and 1 (high byte) in the parity build
      launch("par", 16'h0703);
      check_word("par", 16'h0703, 0);
      wait_clk(CPB / 2 - 1);
      chk("par_busy_last", 16'(busy), 16'd1);
      wait_clk(1);
      chk("par_busy_drop", 16'(busy), 16'd0);
      wait_clk(10);

      // reset mid-DATA with pending and overrun set
      launch("rm", 16'hA55A);
      wait_clk(5);
      queue_word(16'h5555);
      wait_clk(5);
      queue_word(16'h6666);
      wait_clk(25);
      resetN = 1'b0;
      #1;
      chk("rm_txd", 16'(txd), 16'd1);
      chk("rm_busy", 16'(busy), 16'd0);
      rd_status("rm_status", 16'h0000);
      resetN = 1'b1;
      wait_clk(40);
      chk("rm_post_txd", 16'(txd), 16'd1);
      chk("rm_post_busy", 16'(busy), 16'd0);
      rd_status("rm_post_status", 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
